// File: rtl/register_file_param.sv
// Parametrised register file: registered read ports, PC write port, pending-write scoreboard, post-reset clear.
// Define REGFILE_BYPASS_EN to forward same-edge writes to the read ports.
module register_file_param #(
  parameter int DATA_W   = 19,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 0,
  parameter int PC_REG   = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [ADDR_W-1:0] a3,
  input  logic              we3,
  input  logic [DATA_W-1:0] wd3,
  input  logic              pc_we,
  input  logic [DATA_W-1:0] pc_wd,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_addr,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy1,
  output logic              busy2,
  output logic              ready
);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  localparam logic [ADDR_W-1:0] ZR   = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] PR   = ADDR_W'(PC_REG);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_idx;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;

  logic a1_in, a2_in, a3_in, bs_in;

  // Range checks only exist when the index space exceeds the register count.
  if (NUM_REGS < (1 << ADDR_W)) begin : g_rng
    assign a1_in = (int'(a1) < NUM_REGS);
    assign a2_in = (int'(a2) < NUM_REGS);
    assign a3_in = (int'(a3) < NUM_REGS);
    assign bs_in = (int'(busy_addr) < NUM_REGS);
  end else begin : g_full
    assign a1_in = 1'b1;
    assign a2_in = 1'b1;
    assign a3_in = 1'b1;
    assign bs_in = 1'b1;
  end

  logic run, wr_ok, pc_ok, bs_ok, rd1_ok, rd2_ok;

  assign run    = (state == S_RUN);
  assign wr_ok  = run && we3 && a3_in && (a3 != ZR) && (a3 != PR);
  assign pc_ok  = run && pc_we;
  assign bs_ok  = run && busy_set && bs_in && (busy_addr != ZR);
  assign rd1_ok = a1_in && (a1 != ZR);
  assign rd2_ok = a2_in && (a2 != ZR);

  logic [DATA_W-1:0] rd1_n, rd2_n;
  logic              bz1_n, bz2_n;

  always_comb begin
    rd1_n = '0;
    rd2_n = '0;
    bz1_n = 1'b0;
    bz2_n = 1'b0;
    if (rd1_ok) begin
      rd1_n = regs[a1];
      bz1_n = busy[a1];
`ifdef REGFILE_BYPASS_EN
      if (pc_ok && (a1 == PR)) begin
        rd1_n = pc_wd;
        bz1_n = bs_ok && (busy_addr == a1);
      end else if (wr_ok && (a3 == a1)) begin
        rd1_n = wd3;
        bz1_n = bs_ok && (busy_addr == a1);
      end
`endif
    end
    if (rd2_ok) begin
      rd2_n = regs[a2];
      bz2_n = busy[a2];
`ifdef REGFILE_BYPASS_EN
      if (pc_ok && (a2 == PR)) begin
        rd2_n = pc_wd;
        bz2_n = bs_ok && (busy_addr == a2);
      end else if (wr_ok && (a3 == a2)) begin
        rd2_n = wd3;
        bz2_n = bs_ok && (busy_addr == a2);
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_CLEAR;
      clr_idx <= '0;
      rd1     <= '0;
      rd2     <= '0;
      busy1   <= 1'b0;
      busy2   <= 1'b0;
      ready   <= 1'b0;
      busy    <= '0;
    end else if (!run) begin
      clr_idx <= clr_idx + 1'b1;
      rd1     <= '0;
      rd2     <= '0;
      busy1   <= 1'b0;
      busy2   <= 1'b0;
      if (clr_idx == LAST) begin
        state <= S_RUN;
        ready <= 1'b1;
      end
    end else begin
      rd1   <= rd1_n;
      rd2   <= rd2_n;
      busy1 <= bz1_n;
      busy2 <= bz2_n;
      // Set is applied after clear so a same-index set wins.
      if (wr_ok) busy[a3] <= 1'b0;
      if (bs_ok) busy[busy_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if (!run) begin
        regs[clr_idx] <= '0;
      end else begin
        if (wr_ok) regs[a3] <= wd3;
        if (pc_ok) regs[PR] <= pc_wd;
      end
    end
  end

endmodule

// File: doc/register_file_param.md
Name: register_file_param

Overview:
Parametrised successor to the core's single-cycle register file.
- Generic data width and register count.
- Registered (1-cycle) read ports.
- Dedicated PC write port.
- Per-register pending-write scoreboard for hazard detection.
- Post-reset hardware clear sequence.
Sits between decode (read/scoreboard) and writeback (write/clear) in the pipelined datapath.

Parameters:
- DATA_W, 19: register width in bits.
- NUM_REGS, 32: number of architectural registers. Must be ≥ 2.
- ADDR_W, 5: index width. Must be ≥ $clog2(NUM_REGS).
- ZERO_REG, 0: hardwired-zero register index (L0).
- PC_REG, 19: program-counter index. Writable only through the pc_we port.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- a1  in  ADDR_W  read port 1 index.
- a2  in  ADDR_W  read port 2 index.
- a3  in  ADDR_W  writeback index.
- we3  in  1  writeback enable (RegWriteW).
- wd3  in  DATA_W  writeback data (ResultW).
- pc_we  in  1  PC write enable.
- pc_wd  in  DATA_W  PC write data.
- busy_set  in  1  mark register busy_addr as pending.
- busy_addr  in  ADDR_W  register to mark.
- rd1  out  DATA_W  registered read data, port 1.
- rd2  out  DATA_W  registered read data, port 2.
- busy1  out  1  registered pending flag for a1.
- busy2  out  1  registered pending flag for a2.
- ready  out  1  high once the clear sequence is done.

Behaviour:
Reset:
- One clock; reset is synchronous and active-low. Ports are named clk and reset.
- reset==0 at a posedge → state CLEAR, clr_idx=0, rd1=rd2=0, busy1=busy2=0, ready=0, all scoreboard bits=0.
- Reset asserted mid-operation aborts any access and restarts CLEAR.

CLEAR state:
- Each cycle writes 0 to Register[clr_idx], then clr_idx++.
- After the cycle with clr_idx==NUM_REGS-1 → RUN. ready rises on the following edge, so CLEAR lasts exactly NUM_REGS cycles.
- we3, pc_we and busy_set are ignored.
- rd1, rd2, busy1 and busy2 are held at 0.

RUN state, writes:
- Register[a3] <= wd3 when we3 && a3!=ZERO_REG && a3!=PC_REG && a3<NUM_REGS. Otherwise the write is dropped silently.
- Register[PC_REG] <= pc_wd when pc_we. we3 targeting PC_REG is always dropped.

RUN state, reads:
- rd1 and rd2 are sampled from a1 and a2 at the posedge and valid one cycle later.
- Reads of ZERO_REG or an index ≥ NUM_REGS return 0.
- Without bypass, a same-edge write to the read index returns the pre-write value.

Scoreboard:
- busy[busy_addr] <= 1 on busy_set.
- busy[a3] <= 0 on an accepted we3 write.
- Simultaneous set and clear of the same index: set wins (newer producer).
- ZERO_REG is never busy. busy_set to ZERO_REG or an out-of-range index is ignored.
- busy1 and busy2 are registered alongside rd1 and rd2 and reflect state before the same-edge update.

Arithmetic:
- No arithmetic. Data passes through unmodified; all widths are exactly DATA_W.

Optional Feature:
Macro: REGFILE_BYPASS_EN.
- Defined: when an accepted we3 (or pc_we) write matches a1 or a2 on the same edge, rd1/rd2 return wd3 (or pc_wd). Forwarding honours the ZERO_REG and PC_REG rules. The corresponding busy1/busy2 reads 0 unless busy_set targets the same index on that edge.
- Undefined: no forwarding; old value and old busy flag are returned.

Test Plan:
1. Hold reset low 2 cycles, then release → ready=0 for exactly 32 cycles then 1; reading every index gives rd1=rd2=0x00000.
2. RUN: we3=1, a3=5, wd3=0x7FFFF; next cycle a1=5 → rd1=0x7FFFF one cycle later, busy1=0.
3. we3 to a3=0 with 0x12345 and we3 to a3=19 with 0x11111 → both read back 0x00000. Then pc_we=1, pc_wd=0x00400 → a2=19 gives rd2=0x00400.
4. Same edge: we3 a3=7 wd3=0x00ABC and a1=7 (r7 previously 0) → rd1=0x00ABC with REGFILE_BYPASS_EN, 0x00000 without; following read is 0x00ABC in both builds.
5. busy_set r3 → a1=3 gives busy1=1. Same-edge busy_set r3 plus we3 a3=3 → busy1 stays 1. Later we3 a3=3 alone → busy1=0.
6. Write r5=0x0F0F0 and busy_set r5, then drop reset for 1 cycle mid-RUN → ready=0, 32-cycle clear; afterwards r5 reads 0x00000 and busy1=0.
